button_conditioner: RTL
=======================

# button_conditioner

Conditions the five raw push-button inputs (set, up, down, right, left) into clean single-cycle command pulses for the stopwatch block. It sits directly upstream of the stopwatch and drives its `i_set`, `i_up`, `i_down`, `i_right` and `i_left` inputs. Each channel has a two-flop synchroniser, a debounce filter and a rising-edge pulse generator. Channels selected by `REPEAT_MASK` also auto-repeat while the button is held.

## Interface
- `DEBOUNCE_CYCLES`, default 500000: consecutive cycles the synchronised input must differ from the filtered state before the filtered state flips. Legal range ≥1.
- `REPEAT_DELAY`, default 25000000: cycles from the first press pulse to the first repeat pulse. Must be ≥ `REPEAT_PERIOD`.
- `REPEAT_PERIOD`, default 5000000: cycles between subsequent repeat pulses. Legal range ≥1.
- `REPEAT_MASK`, default 5'b00110: per-channel auto-repeat enable. Bit order {left, right, down, up, set}, so the default enables up and down only.
- `i_clk  input  1`: the single clock. All state is on its rising edge.
- `i_rst  input  1`: asynchronous, active-high reset.
- `i_btn_set, i_btn_up, i_btn_down, i_btn_right, i_btn_left  input  1 each`: raw, asynchronous, active-high buttons.
- `o_set, o_up, o_down, o_right, o_left  output  1 each`: registered single-cycle command pulses.

## Operation
- Channels are fully independent. Any combination may pulse in the same cycle; there is no arbitration (the stopwatch controller resolves priority).
- Synchroniser: two flops per channel, named `sync1` and `sync2`.
- Debounce:
  - Per-channel counter `cnt` and filtered state `stable`.
  - If `sync2 == stable`, `cnt` is set to 0.
  - Otherwise `cnt` increments. When `cnt` would reach `DEBOUNCE_CYCLES`, `stable` toggles and `cnt` is cleared.
  - A glitch shorter than `DEBOUNCE_CYCLES` synchronised cycles never changes `stable`.
- Per-channel FSM:
  - IDLE, `stable` rising → PRESS. Emit a press pulse and clear `rcnt`.
  - PRESS, `stable` low → IDLE.
  - PRESS, mask bit set and `rcnt == REPEAT_DELAY-1` → REPEAT. Emit a pulse and clear `rcnt`.
  - REPEAT, `stable` low → IDLE.
  - REPEAT, `rcnt == REPEAT_PERIOD-1` → emit a pulse and clear `rcnt`.
  - In PRESS and REPEAT, `rcnt` otherwise increments.
  - Channels with the mask bit clear stay in PRESS until release and never repeat.
- Release never emits a pulse. Falling `stable` takes priority over a repeat-pulse condition in the same cycle: no pulse is emitted and the FSM goes to IDLE.
- Width rules:
  - `cnt` width is `$clog2(DEBOUNCE_CYCLES+1)`.
  - `rcnt` width is `$clog2(REPEAT_DELAY+1)`.
  - No counter wraps: every counter is cleared before it can reach its limit.

## Timing
- Reset: all sync flops, `stable`, counters and outputs are 0; every FSM is in IDLE. Reset takes effect immediately (asynchronous) and may occur mid-operation.
- A button held through reset deassertion counts as a new press. It pulses after the full press latency and never before.
- Press latency: raw input high before rising edge E1 and held → pulse high for exactly one cycle, starting after edge E(DEBOUNCE_CYCLES+3).
- Repeat pulses:
  - First repeat pulse: `REPEAT_DELAY` cycles after the press pulse.
  - Subsequent repeat pulses: every `REPEAT_PERIOD` cycles thereafter.
  - Each repeat pulse is high for one cycle.
- Release latency: pulses stop no later than `DEBOUNCE_CYCLES+2` edges after the raw input falls.
- Outputs are registered. There is no combinational path from inputs to outputs.

## Structure
- Shared package `button_pkg`:
  - Channel index constants `BTN_SET=0`, `BTN_UP=1`, `BTN_DOWN=2`, `BTN_RIGHT=3`, `BTN_LEFT=4`, and `N_BTN=5`.
  - FSM state typedef with values IDLE, PRESS, REPEAT.
- Sub-module `button_channel`:
  - Contains one synchroniser, debounce filter and FSM.
  - Parameters: `DEBOUNCE_CYCLES`, `REPEAT_DELAY`, `REPEAT_PERIOD`, `REPEAT_EN`.
  - The top level instantiates five `button_channel` instances, with `REPEAT_EN` taken from `REPEAT_MASK` bit i.

## Test plan
All scenarios use `DEBOUNCE_CYCLES`=4, `REPEAT_DELAY`=10, `REPEAT_PERIOD`=3.
- Clean press: hold `i_btn_set` high for 30 cycles → `o_set` is a single 1-cycle pulse after edge 7; `o_set` is never high again, including on release.
- Glitch rejection: drive `i_btn_right` high for 3 cycles, low for 1, repeated 5 times → `o_right` never asserts.
- Auto-repeat: hold `i_btn_up` for 30 cycles → `o_up` pulses after edges 7, 17, 20, 23, 26, 29, then stops within 6 edges of release; `o_set` stays 0 throughout.
- Simultaneous: press `i_btn_down` and `i_btn_left` on the same edge and hold both for 15 cycles → both pulse after edge 7 in the same cycle; only `o_down` repeats, after edge 17.
- Reset mid-operation: hold `i_btn_up`, assert `i_rst` at edge 15 for 2 cycles → all outputs are 0 immediately. With the button still held, the next `o_up` pulse comes `DEBOUNCE_CYCLES+3` edges after reset release, followed by the repeat schedule.
- Bounce on release: at release, toggle the raw input in 2-cycle bursts for 10 cycles → no extra press pulses.

Source files
------------

// File: rtl/button_pkg.sv
// Shared definitions for the push-button conditioner: channel indices and the
// per-channel command state.
package button_pkg;

    localparam int BTN_SET   = 0;
    localparam int BTN_UP    = 1;
    localparam int BTN_DOWN  = 2;
    localparam int BTN_RIGHT = 3;
    localparam int BTN_LEFT  = 4;
    localparam int N_BTN     = 5;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PRESS  = 2'd1,
        REPEAT = 2'd2
    } btn_state_e;

endpackage

// File: rtl/button_channel.sv
// One button: two-flop synchroniser, debounce filter and press/auto-repeat pulse FSM.
//   state  | meaning
//   IDLE   | filtered button released, waiting for a press
//   PRESS  | press pulse issued, counting towards the first repeat
//   REPEAT | auto-repeating every REPEAT_PERIOD cycles while held
module button_channel
    import button_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 5000000,
    parameter bit REPEAT_EN       = 1'b0
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_btn,
    output logic o_pulse
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int RW = $clog2(REPEAT_DELAY + 1);
    localparam logic [CW-1:0] CNT_LAST    = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [RW-1:0] DELAY_LAST  = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] PERIOD_LAST = RW'(REPEAT_PERIOD - 1);

    logic          sync1, sync2;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          stable_q, stable_d;
    logic [RW-1:0] rcnt_q, rcnt_d;
    btn_state_e    state_q, state_d;
    logic          pulse_q, pulse_d;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            sync1    <= 1'b0;
            sync2    <= 1'b0;
            cnt_q    <= '0;
            stable_q <= 1'b0;
            rcnt_q   <= '0;
            state_q  <= IDLE;
            pulse_q  <= 1'b0;
        end else begin
            sync1    <= i_btn;
            sync2    <= sync1;
            cnt_q    <= cnt_d;
            stable_q <= stable_d;
            rcnt_q   <= rcnt_d;
            state_q  <= state_d;
            pulse_q  <= pulse_d;
        end
    end

    // The filtered state flips on the cycle the counter would hit DEBOUNCE_CYCLES.
    always_comb begin
        cnt_d    = '0;
        stable_d = stable_q;
        if (sync2 != stable_q) begin
            if (cnt_q == CNT_LAST) begin
                stable_d = ~stable_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        rcnt_d  = rcnt_q;
        pulse_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (stable_q) begin
                    state_d = PRESS;
                    rcnt_d  = '0;
                    pulse_d = 1'b1;
                end
            end
            PRESS: begin
                // Non-repeating channels park here without counting, so rcnt never wraps.
                if (!stable_q) begin
                    state_d = IDLE;
                end else if (REPEAT_EN && rcnt_q == DELAY_LAST) begin
                    state_d = REPEAT;
                    rcnt_d  = '0;
                    pulse_d = 1'b1;
                end else if (REPEAT_EN) begin
                    rcnt_d = rcnt_q + 1'b1;
                end
            end
            REPEAT: begin
                if (!stable_q) begin
                    state_d = IDLE;
                end else if (rcnt_q == PERIOD_LAST) begin
                    rcnt_d  = '0;
                    pulse_d = 1'b1;
                end else begin
                    rcnt_d = rcnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign o_pulse = pulse_q;

endmodule

// File: rtl/button_conditioner.sv
// Five independent button channels producing single-cycle command pulses for the
// stopwatch; REPEAT_MASK bit order is {left, right, down, up, set}.
module button_conditioner
    import button_pkg::*;
#(
    parameter int               DEBOUNCE_CYCLES = 500000,
    parameter int               REPEAT_DELAY    = 25000000,
    parameter int               REPEAT_PERIOD   = 5000000,
    parameter logic [N_BTN-1:0] REPEAT_MASK     = 5'b00110
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_btn_set,
    input  logic i_btn_up,
    input  logic i_btn_down,
    input  logic i_btn_right,
    input  logic i_btn_left,
    output logic o_set,
    output logic o_up,
    output logic o_down,
    output logic o_right,
    output logic o_left
);

    logic [N_BTN-1:0] btn;
    logic [N_BTN-1:0] pulse;

    assign btn[BTN_SET]   = i_btn_set;
    assign btn[BTN_UP]    = i_btn_up;
    assign btn[BTN_DOWN]  = i_btn_down;
    assign btn[BTN_RIGHT] = i_btn_right;
    assign btn[BTN_LEFT]  = i_btn_left;

    for (genvar i = 0; i < N_BTN; i++) begin : g_chan
        button_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .REPEAT_DELAY    (REPEAT_DELAY),
            .REPEAT_PERIOD   (REPEAT_PERIOD),
            .REPEAT_EN       (REPEAT_MASK[i])
        ) u_chan (
            .i_clk   (i_clk),
            .i_rst   (i_rst),
            .i_btn   (btn[i]),
            .o_pulse (pulse[i])
        );
    end

    assign o_set   = pulse[BTN_SET];
    assign o_up    = pulse[BTN_UP];
    assign o_down  = pulse[BTN_DOWN];
    assign o_right = pulse[BTN_RIGHT];
    assign o_left  = pulse[BTN_LEFT];

endmodule
